// File: rtl/miriscv_timer_pkg.sv
// miriscv_timer_pkg
//   Shared definitions for the memory-mapped timer: register window offsets,
//   the register-index enum, CTRL/STATUS bit positions and a byte-enable
//   merge helper used by every writable register.
//   Optional feature macro used by the timer files: MIRISCV_TIMER_PRESCALER_EN.
package miriscv_timer_pkg;

    // Word offsets inside the 32-byte window (data_addr_i[4:2]).
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_COUNT  = 3'd1;
    localparam logic [2:0] OFF_CMP    = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_PRESC  = 3'd4;

    typedef enum logic [2:0] {
        REG_CTRL   = OFF_CTRL,
        REG_COUNT  = OFF_COUNT,
        REG_CMP    = OFF_CMP,
        REG_STATUS = OFF_STATUS,
        REG_PRESC  = OFF_PRESC
    } reg_idx_e;

    // CTRL bit positions.
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;
    localparam int CTRL_W    = 3;

    // STATUS bit positions.
    localparam int STATUS_PEND = 0;

    localparam int PRESC_W = 16;

    // Replace only the bytes of old_v whose enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/miriscv_timer_presc.sv
// miriscv_timer_presc
//   Tick prescaler: while en is high, emits a one-cycle tick every presc+1
//   cycles. The internal counter restarts from zero whenever en is low or
//   clear is asserted (a PRESC register write).
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   en     - timer enable (CTRL.EN)
//   clear  - restart the prescale count
//   presc  - divide value; tick period is presc+1 cycles
//   tick   - one-cycle count strobe for the timer
module miriscv_timer_presc
    import miriscv_timer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == presc);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/miriscv_timer.sv
// miriscv_timer
//   Memory-mapped 32-bit compare timer with a level interrupt.
//   Registers (word offsets): 0 CTRL {IE,AUTO,EN}, 1 COUNT, 2 CMP,
//   3 STATUS {PEND, write-1-to-clear}, 4 PRESC (prescaler build only).
//   Feature macro: MIRISCV_TIMER_PRESCALER_EN adds a 16-bit PRESC register and
//   the miriscv_timer_presc sub-module; without it the timer ticks every cycle
//   while EN=1 and offset 4 reads 0.
// Ports:
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   data_req_i/we_i     - bus request / write strobe
//   data_be_i           - write byte enables
//   data_addr_i         - byte address
//   data_wdata_i        - write data
//   data_rdata_o        - combinational read data
//   int_fin_i           - interrupt acknowledge, clears PEND
//   int_req_o           - level interrupt request (PEND & IE)
module miriscv_timer
    import miriscv_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    input  logic        int_fin_i,
    output logic        int_req_o
);

    // Bus protocol: single-cycle, always ready. A selected access with
    // data_we_i=1 commits at the next rising edge; with data_we_i=0 the
    // addressed register appears on data_rdata_o in the same cycle. There is
    // no wait state and no ready/valid back-pressure.
    logic       sel, wr, rd;
    logic [2:0] off;

    assign sel = data_req_i && (data_addr_i[31:5] == BASE_ADDR[31:5]);
    assign wr  = sel && data_we_i;
    assign rd  = sel && !data_we_i;
    assign off = data_addr_i[4:2];

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_addr_i[1:0];

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       cmp_q, cmp_d;
    logic              pend_q, pend_d;
    logic              tick;
    logic              pend_set, pend_clr;

`ifdef MIRISCV_TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        presc_merged;
    logic               presc_wr;

    assign presc_wr     = wr && (off == REG_PRESC);
    assign presc_merged = byte_merge({16'h0, presc_q}, data_wdata_i, {2'b00, data_be_i[1:0]});

    always_comb begin
        presc_d = presc_q;
        if (presc_wr) begin
            presc_d = presc_merged[PRESC_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    miriscv_timer_presc u_presc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (ctrl_q[CTRL_EN]),
        .clear (presc_wr),
        .presc (presc_q),
        .tick  (tick)
    );
`else
    assign tick = ctrl_q[CTRL_EN];
`endif

    always_comb begin
        ctrl_d   = ctrl_q;
        count_d  = count_q;
        cmp_d    = cmp_q;
        pend_set = 1'b0;

        // Tick update first; software writes below override it per register
        // (per byte for COUNT, so unselected bytes still advance).
        if (tick) begin
            if (count_q == cmp_q) begin
                pend_set = 1'b1;
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        pend_clr = int_fin_i
                || (wr && (off == REG_STATUS) && data_be_i[0] && data_wdata_i[STATUS_PEND]);

        // A match in the same cycle as an acknowledge must not be lost.
        pend_d = pend_set ? 1'b1 : (pend_clr ? 1'b0 : pend_q);

        if (wr) begin
            case (off)
                REG_CTRL: begin
                    if (data_be_i[0]) begin
                        ctrl_d = data_wdata_i[CTRL_W-1:0];
                    end
                end
                REG_COUNT: count_d = byte_merge(count_d, data_wdata_i, data_be_i);
                REG_CMP:   cmp_d   = byte_merge(cmp_q, data_wdata_i, data_be_i);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q  <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        data_rdata_o = '0;
        if (rd) begin
            case (off)
                REG_CTRL:   data_rdata_o[CTRL_W-1:0]  = ctrl_q;
                REG_COUNT:  data_rdata_o              = count_q;
                REG_CMP:    data_rdata_o              = cmp_q;
                REG_STATUS: data_rdata_o[STATUS_PEND] = pend_q;
`ifdef MIRISCV_TIMER_PRESCALER_EN
                REG_PRESC:  data_rdata_o[PRESC_W-1:0] = presc_q;
`endif
                default: ;
            endcase
        end
    end

    assign int_req_o = pend_q & ctrl_q[CTRL_IE];

endmodule
